// File: rtl/fx2_pkg.sv
// -----------------------------------------------------------------------------
// fx2_pkg
// Shared definitions for the FX2 source arbiter: serializer state encoding,
// frame header marker, PC command opcodes, frame length and the LENGTH
// saturation value, plus a saturating byte-count helper.
// -----------------------------------------------------------------------------
package fx2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  localparam logic        HDR_MARKER  = 1'b1;
  localparam logic [3:0]  OP_ENABLE   = 4'hA;
  localparam logic [7:0]  OP_CLEAR    = 8'hC0;
  localparam logic [15:0] FRAME_BYTES = 16'd3;
  localparam logic [15:0] LENGTH_MAX  = 16'hFFFF;

  // Adds one complete frame to a byte count, sticking at LENGTH_MAX.
  function automatic logic [15:0] add_frame_sat(input logic [15:0] count);
    logic [16:0] sum;
    sum = {1'b0, count} + {1'b0, FRAME_BYTES};
    return sum[16] ? LENGTH_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/fx2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fx2_rr_arbiter
// Purely combinational round-robin selector. Searches the eligible mask
// upward from (last_grant + 1) mod N_SRC with wrap and returns the first hit.
//
// Build option: define FX2_ARB_STRICT0_EN to give source 0 absolute priority;
// the remaining sources still rotate among themselves.
//
// Ports:
//   eligible    in  N_SRC  sources that are valid and enabled
//   last_grant  in  2      id of the most recent grant
//   grant       out N_SRC  one-hot grant (all zero when nothing eligible)
//   grant_id    out 2      binary id of the granted source
//   grant_any   out 1      a grant is being offered
// -----------------------------------------------------------------------------
module fx2_rr_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [1:0]       last_grant,
  output logic [N_SRC-1:0] grant,
  output logic [1:0]       grant_id,
  output logic             grant_any
);

  logic found;

  // NOTE: every output of this block is defaulted first so that no path
  // through the loops can leave a value unassigned and infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;

`ifdef FX2_ARB_STRICT0_EN
    if (eligible[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
`endif

    // Offset 1 is the highest priority, offset N_SRC (last_grant itself) the
    // lowest. Both loops have constant bounds and unroll fully.
    for (int off = 1; off <= N_SRC; off++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && eligible[i] && (i == (int'(last_grant) + off) % N_SRC)) begin
          grant[i] = 1'b1;
          grant_id = 2'(i);
          found    = 1'b1;
        end
      end
    end

    grant_any = found;
  end

endmodule

// File: rtl/fx2_source_arbiter.sv
// -----------------------------------------------------------------------------
// fx2_source_arbiter
// Shares the FPGA->PC byte path of the FX2 FIFO interface between up to four
// pulse-registration sources. One 16-bit event word is captured per grant and
// sent as a 3-byte frame: header {1, seq[2:0], 00, id[1:0]}, high, low.
// Complete-frame bytes are counted and reported through REQUEST_LENGTH;
// PCINSTRUCTION 8'hAx sets the source enable mask, 8'hC0 clears cnt/LENGTH/seq.
//
// Build option: FX2_ARB_STRICT0_EN (see fx2_rr_arbiter) - source 0 strict
// priority. Frame format and length accounting do not depend on it.
//
// Ports:
//   FX2_CLK               in  1         interface clock, rising edge
//   RESET_N               in  1         asynchronous active-low reset
//   SRC_VALID             in  N_SRC     source has a word pending
//   SRC_DATA              in  16*N_SRC  event words, source i at [16i+15:16i]
//   SRC_ACK               out N_SRC     one-cycle pulse, word captured
//   FPGA_WORD             out 8         byte offered to the FX2
//   FPGA_WORD_AVAILIABLE  out 1         FPGA_WORD valid
//   FPGA_WORD_ACCEPTED    in  1         byte taken this cycle
//   PCINSTRUCTION         in  8         PC command byte, 0 = none
//   REQUEST_LENGTH        in  1         PC length query pulse
//   LENGTH                out 16        snapshot of complete-frame bytes
//   SRC_ENABLE            out N_SRC     current enable mask
// -----------------------------------------------------------------------------
module fx2_source_arbiter
  import fx2_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                  FX2_CLK,
  input  logic                  RESET_N,
  input  logic [N_SRC-1:0]      SRC_VALID,
  input  logic [16*N_SRC-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]      SRC_ACK,
  output logic [7:0]            FPGA_WORD,
  output logic                  FPGA_WORD_AVAILIABLE,
  input  logic                  FPGA_WORD_ACCEPTED,
  input  logic [7:0]            PCINSTRUCTION,
  input  logic                  REQUEST_LENGTH,
  output logic [15:0]           LENGTH,
  output logic [N_SRC-1:0]      SRC_ENABLE
);

  state_t             state_q, state_d;
  logic [15:0]        hold_q;
  logic [1:0]         id_q;
  logic [1:0]         last_grant_q;
  logic [N_SRC-1:0]   ack_q;
  logic [2:0]         seq_q;
  logic [15:0]        cnt_q;
  logic [15:0]        length_q;
  logic [N_SRC-1:0]   enable_q;

  logic [N_SRC-1:0]   grant;
  logic [1:0]         grant_id;
  logic               grant_any;
  logic               grant_fire;
  logic [15:0]        sel_word;
  logic               lo_done;
  logic [15:0]        cnt_plus;
  logic               cmd_clear;
  logic               cmd_enable;

  fx2_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .eligible   (SRC_VALID & enable_q),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );

  assign grant_fire = (state_q == ST_IDLE) && grant_any;
  assign lo_done    = (state_q == ST_LO) && FPGA_WORD_ACCEPTED;
  assign cnt_plus   = lo_done ? add_frame_sat(cnt_q) : cnt_q;
  assign cmd_clear  = (PCINSTRUCTION == OP_CLEAR);
  assign cmd_enable = (PCINSTRUCTION[7:4] == OP_ENABLE);

  // Word of the granted source (grant is one-hot or zero).
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) sel_word = SRC_DATA[16*i +: 16];
    end
  end

  // Next-state logic. ACCEPTED only matters while a byte is on offer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_any)          state_d = ST_HDR;
      ST_HDR:  if (FPGA_WORD_ACCEPTED) state_d = ST_HI;
      ST_HI:   if (FPGA_WORD_ACCEPTED) state_d = ST_LO;
      ST_LO:   if (FPGA_WORD_ACCEPTED) state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Byte outputs come only from registered state, so the FX2 side never sees
  // a combinational path from FPGA_WORD_ACCEPTED.
  always_comb begin
    FPGA_WORD            = 8'h00;
    FPGA_WORD_AVAILIABLE = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        FPGA_WORD            = {HDR_MARKER, seq_q, 2'b00, id_q};
        FPGA_WORD_AVAILIABLE = 1'b1;
      end
      ST_HI: begin
        FPGA_WORD            = hold_q[15:8];
        FPGA_WORD_AVAILIABLE = 1'b1;
      end
      ST_LO: begin
        FPGA_WORD            = hold_q[7:0];
        FPGA_WORD_AVAILIABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the hold register is reset along with the control state even though
  // it is only read after a capture; it is a single word, and a defined value
  // keeps FPGA_WORD deterministic from the very first frame.
  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      id_q         <= '0;
      last_grant_q <= 2'(N_SRC - 1);
      ack_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      ack_q   <= grant_fire ? grant : '0;
      if (grant_fire) begin
        hold_q       <= sel_word;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
    end
  end

  // Sequence number, byte count, length snapshot and enable mask. A clear
  // command overrides both a same-cycle length request and frame completion.
  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seq_q    <= '0;
      cnt_q    <= '0;
      length_q <= '0;
      enable_q <= '1;
    end else begin
      if (cmd_enable) enable_q <= PCINSTRUCTION[N_SRC-1:0];

      if (cmd_clear) begin
        seq_q    <= '0;
        cnt_q    <= '0;
        length_q <= '0;
      end else begin
        if (lo_done) seq_q <= seq_q + 3'd1;
        if (REQUEST_LENGTH) begin
          length_q <= cnt_plus;
          cnt_q    <= '0;
        end else begin
          cnt_q    <= cnt_plus;
        end
      end
    end
  end

  assign SRC_ACK    = ack_q;
  assign LENGTH     = length_q;
  assign SRC_ENABLE = enable_q;

endmodule

// File: doc/fx2_source_arbiter.md
# fx2_source_arbiter

- Shares the single FPGA→PC byte path of the FX2 bidirectional FIFO interface between up to four pulse-registration sources.
- Grants sources round-robin, captures one 16-bit event word per grant and serializes it as a 3-byte frame (header, high, low) over the FPGA_WORD handshake.
- Keeps the byte count the PC requests through REQUEST_LENGTH.
- Applies source-enable commands decoded from PCINSTRUCTION.

## Interface
Parameters:
- N_SRC, 4, number of sources, legal 1..4

Ports:
- FX2_CLK  in  1  FX2 interface clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- SRC_VALID  in  N_SRC  source i has an event word pending
- SRC_DATA  in  16*N_SRC  event words; source i at [16i+15:16i]
- SRC_ACK  out  N_SRC  one-cycle pulse: word of source i captured
- FPGA_WORD  out  8  byte offered to the FX2 interface
- FPGA_WORD_AVAILIABLE  out  1  FPGA_WORD valid
- FPGA_WORD_ACCEPTED  in  1  byte taken this cycle
- PCINSTRUCTION  in  8  PC command byte; 0 when no command
- REQUEST_LENGTH  in  1  one-cycle pulse: PC queries length
- LENGTH  out  16  snapshot of complete-frame bytes
- SRC_ENABLE  out  N_SRC  current enable mask (status)

## Operation
- States: IDLE, HDR, HI, LO.
- IDLE:
  - Eligible = SRC_VALID & SRC_ENABLE.
  - If any source is eligible: grant the first eligible one searching upward from (last_grant+1) mod N_SRC, with wrap.
  - Capture its word into hold register, latch grant id, go to HDR.
- HDR / HI / LO: FPGA_WORD_AVAILIABLE=1.
  - FPGA_WORD is header / hold[15:8] / hold[7:0] respectively.
  - A state advances only on a cycle with FPGA_WORD_ACCEPTED=1: HDR→HI→LO→IDLE.
  - Otherwise the state holds and FPGA_WORD stays stable.
- Header byte: {1'b1, seq[2:0], 2'b00, id[1:0]}.
  - seq is a 3-bit frame counter; it increments when LO is accepted and wraps 7→0.
- SRC_ACK[id] is high exactly in the first HDR cycle of a frame; the source may change SRC_DATA from the next cycle.
- Length accounting:
  - Byte counter cnt (16 bits) adds 3 when LO is accepted, saturating at 16'hFFFF.
  - Partial frames are never counted.
  - On REQUEST_LENGTH: LENGTH <= cnt (+3 if LO is accepted in the same cycle, saturating), and cnt <= 0.
  - LENGTH is held between requests.
- Commands:
  - PCINSTRUCTION[7:4]==4'hA: SRC_ENABLE <= PCINSTRUCTION[N_SRC-1:0].
  - 8'hC0: clear cnt, LENGTH and seq.
  - All other values are ignored.
  - Disabling the source currently in a frame does not abort the frame.
- FPGA_WORD_ACCEPTED outside HDR/HI/LO is ignored.

## Timing
- Reset values: state IDLE, SRC_ACK 0, FPGA_WORD 8'h00, FPGA_WORD_AVAILIABLE 0, LENGTH 0, SRC_ENABLE all ones, cnt 0, seq 0, last_grant N_SRC-1.
- Grant latency: SRC_VALID sampled high in IDLE at edge k → HDR and SRC_ACK from edge k to k+1.
- Throughput: with ACCEPTED held high, one frame per 4 cycles (3 bytes plus 1 IDLE).
- FPGA_WORD and FPGA_WORD_AVAILIABLE are decoded from registered state and the hold register only; there is no combinational path from FPGA_WORD_ACCEPTED.
- REQUEST_LENGTH to LENGTH valid: 1 cycle.
- Simultaneous command 8'hC0 and REQUEST_LENGTH: the clear wins; LENGTH=0.
- Reset asserted mid-frame: the frame is dropped, no SRC_ACK is reissued, and all registers take their reset values immediately.

## Configuration
- FX2_ARB_STRICT0_EN defined: source 0, when eligible in IDLE, is always granted first; the others rotate round-robin among themselves.
- FX2_ARB_STRICT0_EN undefined: pure round-robin over all sources.
- Frame format and length accounting are identical in both builds.

## Structure
- Shared package fx2_pkg holds:
  - state encoding constants
  - header marker bit
  - command opcodes (4'hA enable, 8'hC0 clear)
  - frame length constant 3
  - LENGTH saturation value
- One sub-module: fx2_rr_arbiter (eligible mask + last_grant → one-hot grant and id; contains the STRICT0 option).
- Serializer, counter and command decode stay in the top.

## Test plan
- Reset, then N_SRC=4, SRC_VALID=4'b0001, data 16'h1234, ACCEPTED always 1 → bytes 8'h80, 8'h12, 8'h34; SRC_ACK[0] for one cycle; after REQUEST_LENGTH, LENGTH=3.
- All four sources valid continuously, no STRICT0 → grant order 0,1,2,3,0; headers 8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC0.
- Same stimulus with FX2_ARB_STRICT0_EN → every frame from source 0.
- ACCEPTED low for 5 cycles in HI → FPGA_WORD stays at the high byte with AVAILIABLE=1; the sequence resumes on the first accept.
- REQUEST_LENGTH pulsed after the HDR and HI bytes of a frame are accepted, with cnt=6 → LENGTH=6 and cnt becomes 0. Next REQUEST_LENGTH, after the frame completes → LENGTH=3.
- PCINSTRUCTION=8'hA5 with sources 0 and 2 valid → SRC_ENABLE=4'b0101 and only sources 0 and 2 are granted. 8'hC0 during REQUEST_LENGTH → LENGTH=0. RESET_N low mid-HI → outputs at reset values the same cycle.
